// File: rtl/clock_pkg.sv
// Shared definitions for the calendar databus writer: field indices, legal
// ranges, the loader state encoding and error-kind codes.
package clock_pkg;

  localparam int NUM_FIELDS = 7;
  localparam int FW         = 6;

  typedef logic [2:0]                      field_idx_t;
  typedef logic [NUM_FIELDS-1:0][FW-1:0]   field_vec_t;

  localparam field_idx_t F_SEC   = 3'd0;
  localparam field_idx_t F_MIN   = 3'd1;
  localparam field_idx_t F_HOUR  = 3'd2;
  localparam field_idx_t F_DAY   = 3'd3;
  localparam field_idx_t F_DATE  = 3'd4;
  localparam field_idx_t F_MONTH = 3'd5;
  localparam field_idx_t F_YEAR  = 3'd6;

  // Packed index 6 (year) is leftmost.
  localparam field_vec_t FIELD_MIN = {6'd0,  6'd1,  6'd1,  6'd0, 6'd0,  6'd0,  6'd0};
  localparam field_vec_t FIELD_MAX = {6'd63, 6'd12, 6'd31, 6'd6, 6'd23, 6'd59, 6'd59};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_FREEZE,
    ST_WRITE,
    ST_VERIFY,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam logic ERR_KIND_RANGE    = 1'b0;
  localparam logic ERR_KIND_READBACK = 1'b1;

endpackage

// File: rtl/field_range_check.sv
// Registered range checker: flags any out-of-range field and reports the
// lowest failing index, updated on the same edge the shadow fields load.
module field_range_check
  import clock_pkg::*;
#(
  parameter int YEAR_MAX = 63
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       load,
  input  field_vec_t fields,
  output logic       fail,
  output logic [2:0] fail_idx
);

  field_vec_t lim_max;
  logic       fail_c;
  field_idx_t idx_c;

  always_comb begin
    lim_max         = FIELD_MAX;
    lim_max[F_YEAR] = YEAR_MAX[FW-1:0];
    fail_c          = 1'b0;
    idx_c           = '0;
    // Descending scan so the lowest failing index wins.
    for (int i = NUM_FIELDS - 1; i >= 0; i--) begin
      if ((fields[i] < FIELD_MIN[i]) || (fields[i] > lim_max[i])) begin
        fail_c = 1'b1;
        idx_c  = field_idx_t'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      fail     <= 1'b0;
      fail_idx <= '0;
    end else if (load) begin
      fail     <= fail_c;
      fail_idx <= idx_c;
    end
  end

endmodule

// File: rtl/calendar_loader.sv
// Writer side of the 6-bit calendar databus: captures a time/date set request,
// range-checks it, then loads (and optionally reads back) each counter in turn.
module calendar_loader
  import clock_pkg::*;
#(
  parameter bit VERIFY_EN = 1'b1,
  parameter int YEAR_MAX  = 63
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       start,
  input  logic [5:0] sec_in,
  input  logic [5:0] min_in,
  input  logic [4:0] hour_in,
  input  logic [2:0] day_in,
  input  logic [4:0] date_in,
  input  logic [3:0] month_in,
  input  logic [5:0] year_in,
  input  logic [5:0] bus_in,
  output logic [5:0] bus_out,
  output logic       drive_en,
  output logic [6:0] load_sel,
  output logic [6:0] rd_sel,
  output logic       count_hold,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [2:0] err_field,
  output logic       err_kind
);

  state_t     state, nxt;
  field_vec_t shadow, shadow_d;
  field_idx_t idx;
  field_idx_t range_idx;
  logic       range_fail;
  logic       capture, last_field, rb_match, advance;

  assign shadow_d   = {year_in, {2'b00, month_in}, {1'b0, date_in}, {3'b000, day_in},
                       {1'b0, hour_in}, min_in, sec_in};
  assign capture    = (state == ST_IDLE) && start;
  assign last_field = (idx == F_YEAR);
  assign rb_match   = (bus_in == shadow[idx]);
  assign advance    = ((state == ST_WRITE) && !VERIFY_EN) || ((state == ST_VERIFY) && rb_match);

  // Checker loads alongside the shadow registers so its verdict is ready in CHECK.
  field_range_check #(.YEAR_MAX(YEAR_MAX)) u_range (
    .clk      (clk),
    .clear    (clear),
    .load     (capture),
    .fields   (shadow_d),
    .fail     (range_fail),
    .fail_idx (range_idx)
  );

  always_ff @(posedge clk) begin
    if (clear) state <= ST_IDLE;
    else       state <= nxt;
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      shadow    <= '0;
      idx       <= '0;
      err_field <= '0;
      err_kind  <= ERR_KIND_RANGE;
    end else begin
      if (capture) begin
        shadow    <= shadow_d;
        idx       <= '0;
        err_field <= '0;
        err_kind  <= ERR_KIND_RANGE;
      end
      if (advance) idx <= idx + 3'd1;
      if ((state == ST_CHECK) && range_fail) begin
        err_field <= range_idx;
        err_kind  <= ERR_KIND_RANGE;
      end
      if ((state == ST_VERIFY) && !rb_match) begin
        err_field <= idx;
        err_kind  <= ERR_KIND_READBACK;
      end
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:   if (start) nxt = ST_CHECK;
      ST_CHECK:  nxt = range_fail ? ST_ERR : ST_FREEZE;
      ST_FREEZE: nxt = ST_WRITE;
      ST_WRITE: begin
        if (VERIFY_EN)       nxt = ST_VERIFY;
        else if (last_field) nxt = ST_DONE;
        else                 nxt = ST_WRITE;
      end
      ST_VERIFY: begin
        if (!rb_match)       nxt = ST_ERR;
        else if (last_field) nxt = ST_DONE;
        else                 nxt = ST_WRITE;
      end
      ST_DONE:   nxt = ST_IDLE;
      ST_ERR:    nxt = ST_IDLE;
      default:   nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus_out    = '0;
    drive_en   = 1'b0;
    load_sel   = '0;
    rd_sel     = '0;
    count_hold = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    case (state)
      ST_CHECK:  busy = 1'b1;
      ST_FREEZE: begin
        busy       = 1'b1;
        count_hold = 1'b1;
      end
      ST_WRITE: begin
        busy       = 1'b1;
        count_hold = 1'b1;
        drive_en   = 1'b1;
        bus_out    = shadow[idx];
        load_sel   = 7'd1 << idx;
      end
      ST_VERIFY: begin
        busy       = 1'b1;
        count_hold = 1'b1;
        rd_sel     = 7'd1 << idx;
      end
      ST_DONE:   done = 1'b1;
      ST_ERR:    err  = 1'b1;
      default:   ;
    endcase
  end

endmodule
